// File: rtl/servo_pwm_bank_if.sv
// Bus bundle for servo_pwm_bank.
//   pul_len : requested pulse widths in us, channel i at [16*i+15:16*i]
//   load    : strobe capturing all of pul_len into the target registers
//   en      : per-channel enable, taken at frame boundaries
//   ctl     : servo control outputs
//   frame   : one-cycle pulse on every frame-boundary cycle
//   settled : high when every channel's active width equals its target
// The master side is the controller (gait sequencer); the slave side is the PWM bank.
interface servo_pwm_bank_if #(
  parameter int N_CH = 6
);
  logic [16*N_CH-1:0] pul_len;
  logic               load;
  logic [N_CH-1:0]    en;
  logic [N_CH-1:0]    ctl;
  logic               frame;
  logic               settled;

  modport master (
    output pul_len,
    output load,
    output en,
    input  ctl,
    input  frame,
    input  settled
  );

  modport slave (
    input  pul_len,
    input  load,
    input  en,
    output ctl,
    output frame,
    output settled
  );
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM generator.
// All channels share one prescaler (CLK_DIV clocks per 1 us tick) and one frame
// counter (PERIOD_US ticks per frame), so every pulse rises on the same clock.
// Requested widths are clamped into [PW_MIN, PW_MAX] and held as targets; the
// active widths follow the targets only at frame boundaries, optionally limited
// to MAX_STEP us per frame, so no runt or glitched pulse is ever produced.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of servo_pwm_bank_if (pul_len, load, en, ctl, frame, settled)
module servo_pwm_bank #(
  parameter int N_CH      = 6,
  parameter int CLK_DIV   = 50,
  parameter int PERIOD_US = 20000,
  parameter int PW_MIN    = 500,
  parameter int PW_MAX    = 2500,
  parameter int PW_INIT   = 1500,
  parameter int MAX_STEP  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  servo_pwm_bank_if.slave     bus
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CLK_DIV - 1);
  localparam logic [15:0]       CNT_LAST  = 16'(PERIOD_US - 1);
  localparam logic [15:0]       PW_MIN_V  = 16'(PW_MIN);
  localparam logic [15:0]       PW_MAX_V  = 16'(PW_MAX);
  localparam logic [15:0]       PW_INIT_V = 16'(PW_INIT);
  localparam logic [15:0]       STEP_V    = 16'(MAX_STEP);
  localparam logic signed [16:0] STEP_S   = 17'(MAX_STEP);

  // Clamp a requested width into the safe pulse range.
  function automatic logic [15:0] clamp_pw(input logic [15:0] req);
    if (req < PW_MIN_V) begin
      return PW_MIN_V;
    end else if (req > PW_MAX_V) begin
      return PW_MAX_V;
    end else begin
      return req;
    end
  endfunction

  // One frame's movement of an active width toward its target. The difference is
  // taken in 17-bit signed so no width combination can wrap, and the last step
  // lands exactly on the target instead of overshooting it.
  function automatic logic [15:0] slew_pw(input logic [15:0] act, input logic [15:0] tgt);
    logic signed [16:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, act});
    if (MAX_STEP == 0) begin
      return tgt;
    end else if (diff > STEP_S) begin
      return act + STEP_V;
    end else if (diff < -STEP_S) begin
      return act - STEP_V;
    end else begin
      return tgt;
    end
  endfunction

  logic [PS_W-1:0] prescaler_r;
  logic [15:0]     count_r;
  logic [15:0]     target_r [N_CH];
  logic [15:0]     active_r [N_CH];
  logic [N_CH-1:0] en_act_r;
  logic [N_CH-1:0] ctl_r;
  logic            frame_r;
  logic            settled_r;

  logic            tick_s;
  logic            boundary_s;
  logic [15:0]     count_next_s;
  logic [15:0]     active_next_s [N_CH];
  logic [N_CH-1:0] en_act_next_s;
  logic [N_CH-1:0] ctl_next_s;
  logic            settled_next_s;

  // Tick, boundary and next-state values for the counter, widths and enables.
  always_comb begin
    tick_s     = (prescaler_r == PS_LAST);
    boundary_s = tick_s && (count_r == CNT_LAST);
    if (!tick_s) begin
      count_next_s = count_r;
    end else if (count_r == CNT_LAST) begin
      count_next_s = 16'd0;
    end else begin
      count_next_s = count_r + 16'd1;
    end
    en_act_next_s = boundary_s ? bus.en : en_act_r;
    for (int i = 0; i < N_CH; i++) begin
      active_next_s[i] = boundary_s ? slew_pw(active_r[i], target_r[i]) : active_r[i];
    end
  end

  // Pulse levels as they will be after this edge, and the settled condition.
  always_comb begin
    ctl_next_s     = '0;
    settled_next_s = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      ctl_next_s[i]  = en_act_next_s[i] && (count_next_s < active_next_s[i]);
      settled_next_s = settled_next_s && (active_r[i] == target_r[i]);
    end
  end

  // Prescaler and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_r <= '0;
      count_r     <= CNT_LAST;
    end else begin
      prescaler_r <= tick_s ? '0 : prescaler_r + PS_W'(1);
      count_r     <= count_next_s;
    end
  end

  // Target capture on LOAD; a LOAD on a boundary still feeds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        target_r[i] <= PW_INIT_V;
      end
    end else if (bus.load) begin
      for (int i = 0; i < N_CH; i++) begin
        target_r[i] <= clamp_pw(bus.pul_len[16*i +: 16]);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        target_r[i] <= target_r[i];
      end
    end
  end

  // Active widths and latched enables, changing only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        active_r[i] <= PW_INIT_V;
      end
      en_act_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        active_r[i] <= active_next_s[i];
      end
      en_act_r <= en_act_next_s;
    end
  end

  // Registered outputs; CTL only moves on ticks so each pulse is whole ticks long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_r     <= '0;
      frame_r   <= 1'b0;
      settled_r <= 1'b1;
    end else begin
      ctl_r     <= tick_s ? ctl_next_s : ctl_r;
      frame_r   <= boundary_s;
      settled_r <= settled_next_s;
    end
  end

  assign bus.ctl     = ctl_r;
  assign bus.frame   = frame_r;
  assign bus.settled = settled_r;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: two instances (no slew / 15 us slew) with
// CLK_DIV=2, PERIOD_US=100, PW_MIN=10, PW_MAX=80, PW_INIT=50, N_CH=2.
// A frame is 200 clocks; a width of W us keeps CTL high for 2*W clocks.
module tb_servo_pwm_bank;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  int   ac0, ac1, bc0, bc1;
  logic as_s, bs_s;

  servo_pwm_bank_if #(.N_CH(2)) if_a ();
  servo_pwm_bank_if #(.N_CH(2)) if_b ();

  servo_pwm_bank #(
    .N_CH(2), .CLK_DIV(2), .PERIOD_US(100), .PW_MIN(10), .PW_MAX(80),
    .PW_INIT(50), .MAX_STEP(0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  servo_pwm_bank #(
    .N_CH(2), .CLK_DIV(2), .PERIOD_US(100), .PW_MIN(10), .PW_MAX(80),
    .PW_INIT(50), .MAX_STEP(15)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for a FRAME pulse on instance A, sampled on falling edges.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (if_a.frame !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(if_a.frame), 1);
  endtask

  // Starting on the falling edge after a boundary, count high cycles over one
  // whole frame; optionally drop en_a[1] at sample drop_at. Ends on the
  // falling edge after the next boundary.
  task automatic measure(input string tag, input int drop_at);
    int fr;
    fr  = 0;
    ac0 = 0; ac1 = 0; bc0 = 0; bc1 = 0;
    as_s = 1'bx; bs_s = 1'bx;
    for (int i = 0; i < 200; i++) begin
      if (i == drop_at) if_a.en = 2'b01;
      if (if_a.ctl[0] === 1'b1) ac0++;
      if (if_a.ctl[1] === 1'b1) ac1++;
      if (if_b.ctl[0] === 1'b1) bc0++;
      if (if_b.ctl[1] === 1'b1) bc1++;
      if (if_a.frame === 1'b1) fr++;
      if (i == 1) begin
        as_s = if_a.settled;
        bs_s = if_b.settled;
      end
      @(negedge clk);
    end
    check({tag, "_frame_once"}, fr, 1);
    check({tag, "_frame_period"}, int'(if_a.frame), 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    if_a.pul_len = '0;
    if_a.load    = 1'b0;
    if_a.en      = 2'b11;
    if_b.pul_len = '0;
    if_b.load    = 1'b0;
    if_b.en      = 2'b11;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ctl", int'(if_a.ctl), 0);
    check("rst_frame", int'(if_a.frame), 0);
    check("rst_settled", int'(if_a.settled), 1);

    // 1: first boundary on edge 2, 50 us pulses on both channels.
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_edge1_frame", int'(if_a.frame), 0);
    check("t1_edge1_ctl", int'(if_a.ctl), 0);
    @(negedge clk);
    check("t1_edge2_frame", int'(if_a.frame), 1);
    check("t1_edge2_ctl", int'(if_a.ctl), 3);
    check("t1_edge2_frame_b", int'(if_b.frame), 1);
    measure("t1", -1);
    check("t1_a_ch0", ac0, 100);
    check("t1_a_ch1", ac1, 100);
    check("t1_b_ch0", bc0, 100);
    check("t1_settled", int'(as_s), 1);

    // 2 and 3: clamped LOAD on A, slewed LOAD on B, mid-frame.
    if_a.pul_len = {16'd200, 16'd5};
    if_b.pul_len = {16'd50, 16'd80};
    if_a.load    = 1'b1;
    if_b.load    = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0;
    if_b.load = 1'b0;
    @(negedge clk);
    check("t2_settled_drop_a", int'(if_a.settled), 0);
    check("t3_settled_drop_b", int'(if_b.settled), 0);
    wait_frame("t2_wait");
    measure("t2f1", -1);
    check("t2_a_ch0_clamp_lo", ac0, 20);
    check("t2_a_ch1_clamp_hi", ac1, 160);
    check("t2_settled_a", int'(as_s), 1);
    check("t3_b_ch0_step1", bc0, 130);
    check("t3_b_ch1", bc1, 100);
    check("t3_settled_b_1", int'(bs_s), 0);
    measure("t3f2", -1);
    check("t3_b_ch0_step2", bc0, 160);
    check("t3_settled_b_2", int'(bs_s), 1);
    check("t2_a_ch0_hold", ac0, 20);
    measure("t3f3", -1);
    check("t3_b_ch0_step3", bc0, 160);

    // 4: LOAD on the boundary cycle itself.
    repeat (199) @(negedge clk);
    if_a.pul_len = {16'd70, 16'd30};
    if_a.load    = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0;
    check("t4_on_boundary", int'(if_a.frame), 1);
    measure("t4f1", -1);
    check("t4_old_ch0", ac0, 20);
    check("t4_old_ch1", ac1, 160);
    check("t4_settled_low", int'(as_s), 0);
    measure("t4f2", -1);
    check("t4_new_ch0", ac0, 60);
    check("t4_new_ch1", ac1, 140);
    check("t4_settled_high", int'(as_s), 1);

    // 5: drop en[1] mid-pulse.
    measure("t5f1", 50);
    check("t5_ch0_same", ac0, 60);
    check("t5_ch1_completes", ac1, 140);
    measure("t5f2", -1);
    check("t5_ch0_next", ac0, 60);
    check("t5_ch1_off", ac1, 0);

    // 6: asynchronous reset while CTL is high.
    check("t6_ctl_high_before", int'(if_a.ctl[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_ctl_a", int'(if_a.ctl), 0);
    check("t6_async_ctl_b", int'(if_b.ctl), 0);
    check("t6_async_frame", int'(if_a.frame), 0);
    check("t6_async_settled", int'(if_a.settled), 1);
    @(negedge clk);
    if_a.en = 2'b11;
    rst_n   = 1'b1;
    @(negedge clk);
    check("t6_edge1_frame", int'(if_a.frame), 0);
    @(negedge clk);
    check("t6_edge2_frame", int'(if_a.frame), 1);
    measure("t6", -1);
    check("t6_a_ch0", ac0, 100);
    check("t6_a_ch1", ac1, 100);
    check("t6_b_ch0", bc0, 100);
    check("t6_b_ch1", bc1, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
